// File: rtl/hamming_pkg.sv
// Shared definitions for the 12-bit Hamming (8 data + 4 parity) codec:
// widths, bit-position tables and the syndrome-to-error-index map.
package hamming_pkg;

    localparam int unsigned CW_W   = 12;
    localparam int unsigned DATA_W = 8;

    typedef logic [3:0] syndrome_t;

    // Codeword positions holding d0..d7 and the four parity bits.
    localparam logic [3:0] DATA_IDX [DATA_W] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
    localparam logic [3:0] PAR_IDX  [4]      = '{4'd0, 4'd1, 4'd3, 4'd7};

    typedef struct packed {
        logic       valid;  // syndrome points at a single codeword bit
        logic [3:0] idx;    // position of that bit
    } syn_idx_t;

    // Map a syndrome to the codeword bit to flip; 0000 and 1100..1110 are not mapped.
    function automatic syn_idx_t syn2idx(input syndrome_t s);
        syn_idx_t r;
        r.valid = 1'b1;
        r.idx   = '0;
        case (s)
            4'b0001: r.idx = 4'd0;
            4'b0011: r.idx = 4'd1;
            4'b0010: r.idx = 4'd2;
            4'b0111: r.idx = 4'd3;
            4'b0100: r.idx = 4'd4;
            4'b0101: r.idx = 4'd5;
            4'b0110: r.idx = 4'd6;
            4'b1111: r.idx = 4'd7;
            4'b1000: r.idx = 4'd8;
            4'b1001: r.idx = 4'd9;
            4'b1010: r.idx = 4'd10;
            4'b1011: r.idx = 4'd11;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome generator for a 12-bit codeword; shared with scrub logic.
module hamming_syndrome_calc
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0] cw_i,
    output syndrome_t       syn_o
);

    // Parity checks over the bit groups covered by each syndrome bit.
    always_comb begin
        syn_o[0] = cw_i[0] ^ cw_i[1] ^ cw_i[3] ^ cw_i[5] ^ cw_i[7] ^ cw_i[9] ^ cw_i[11];
        syn_o[1] = cw_i[1] ^ cw_i[2] ^ cw_i[3] ^ cw_i[6] ^ cw_i[7] ^ cw_i[10] ^ cw_i[11];
        syn_o[2] = cw_i[3] ^ cw_i[4] ^ cw_i[5] ^ cw_i[6] ^ cw_i[7];
        syn_o[3] = cw_i[7] ^ cw_i[8] ^ cw_i[9] ^ cw_i[10] ^ cw_i[11];
    end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage pipelined SEC Hamming decoder (syndrome stage, correct/flag stage)
// with valid/ready on both sides. Define HAMMING_DEC_ERR_CNT_EN to add the
// saturating corrected/uncorrectable error counters and their cnt_clr input.
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   codeword_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              single_err,
    output logic              uncorr_err,
    output syndrome_t         syndrome_out
`ifdef HAMMING_DEC_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

    if (PIPE_STAGES != 2) begin : g_bad_depth
        $error("hamming_decoder: PIPE_STAGES must be 2");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("hamming_decoder: CNT_W must be non-zero");
    end

    logic              s1_valid_q, s1_valid_d;
    logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
    syndrome_t         s1_syn_q, s1_syn_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              single_q, single_d;
    logic              uncorr_q, uncorr_d;
    syndrome_t         syn_q, syn_d;

    syndrome_t         syn_w;
    logic              stage2_free;
    logic              accept;
    syn_idx_t          idx_r;
    logic [CW_W-1:0]   cw_fix;
    logic [DATA_W-1:0] fix_data;
    logic              fix_single;
    logic              fix_uncorr;

    hamming_syndrome_calc u_syn (
        .cw_i  (codeword_in),
        .syn_o (syn_w)
    );

    assign stage2_free = !out_valid_q | out_ready;
    assign in_ready    = !s1_valid_q | stage2_free;
    assign accept      = in_valid & in_ready;

    // Correct the stage-1 word and classify its syndrome.
    always_comb begin
        idx_r  = syn2idx(s1_syn_q);
        cw_fix = s1_cw_q;
        if (idx_r.valid) begin
            cw_fix[idx_r.idx] = ~cw_fix[idx_r.idx];
        end
        fix_data = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fix_data[i] = cw_fix[DATA_IDX[i]];
        end
        fix_single = idx_r.valid;
        fix_uncorr = !idx_r.valid && (s1_syn_q != '0);
    end

    // Pipeline advance: stage 1 loads on accept, stage 2 loads whenever it is free.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_cw_d     = s1_cw_q;
        s1_syn_d    = s1_syn_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        single_d    = single_q;
        uncorr_d    = uncorr_q;
        syn_d       = syn_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_cw_d    = codeword_in;
            s1_syn_d   = syn_w;
        end else if (stage2_free) begin
            s1_valid_d = 1'b0;
        end

        // A bubble load clears the flags; data and syndrome keep their last value.
        if (stage2_free) begin
            out_valid_d = s1_valid_q;
            single_d    = 1'b0;
            uncorr_d    = 1'b0;
            if (s1_valid_q) begin
                data_d   = fix_data;
                single_d = fix_single;
                uncorr_d = fix_uncorr;
                syn_d    = s1_syn_q;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_cw_q     <= '0;
            s1_syn_q    <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            single_q    <= 1'b0;
            uncorr_q    <= 1'b0;
            syn_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cw_q     <= s1_cw_d;
            s1_syn_q    <= s1_syn_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            single_q    <= single_d;
            uncorr_q    <= uncorr_d;
            syn_q       <= syn_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign data_out     = data_q;
    assign single_err   = single_q;
    assign uncorr_err   = uncorr_q;
    assign syndrome_out = syn_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic             out_hs;

    assign out_hs = out_valid_q & out_ready;

    // Saturating error counters; clear wins over a same-cycle increment.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_hs) begin
            if (single_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (uncorr_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed codewords, full-rate
// streaming, back-pressure, random traffic and mid-stream reset, all checked
// against a column-table Hamming reference model and an occupancy model.
module tb_hamming_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] codeword_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;
    logic        single_err;
    logic        uncorr_err;
    logic [3:0]  syndrome_out;
`ifdef HAMMING_DEC_ERR_CNT_EN
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    int unsigned exp_corr;
    int unsigned exp_unc;
`endif

    always #5 clk = ~clk;

    hamming_decoder #(.PIPE_STAGES(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .codeword_in  (codeword_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .single_err   (single_err),
        .uncorr_err   (uncorr_err),
        .syndrome_out (syndrome_out)
`ifdef HAMMING_DEC_ERR_CNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic       single;
        logic       uncorr;
        logic [3:0] syn;
    } ref_t;

    // Syndrome column contributed by each codeword bit, and data bit positions.
    logic [3:0] COL  [12] = '{4'h1, 4'h3, 4'h2, 4'h7, 4'h4, 4'h5, 4'h6, 4'hF, 4'h8, 4'h9, 4'hA, 4'hB};
    logic [3:0] DPOS [8]  = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};

    int   n_vec = 0;
    int   n_err = 0;
    int   occ = 0;
    int   delivered = 0;
    ref_t q[$];

    function automatic ref_t ref_decode(input logic [11:0] cw);
        ref_t       r;
        logic [3:0] s     = 4'h0;
        logic       found = 1'b0;
        logic [11:0] fixed = cw;
        for (int i = 0; i < 12; i++) if (cw[i]) s = s ^ COL[i];
        for (int i = 0; i < 12; i++) begin
            if (COL[i] == s) begin
                found = 1'b1;
                fixed[i] = ~fixed[i];
            end
        end
        r.syn    = s;
        r.single = found;
        r.uncorr = (s != 4'h0) && !found;
        for (int j = 0; j < 8; j++) r.data[j] = fixed[DPOS[j]];
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at posedge+1. exp_ov < 0 skips the out_valid check.
    task automatic cycle(input logic v, input logic [11:0] cw, input logic rdy,
                         input int exp_ov, output logic acc);
        ref_t e = '0;
        logic hs;
        in_valid    = v;
        codeword_in = cw;
        out_ready   = rdy;
        #2;
        check_eq("in_ready", 32'(in_ready), 32'((occ < 2) || rdy));
        if (exp_ov >= 0) check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
`ifdef HAMMING_DEC_ERR_CNT_EN
        check_eq("corr_cnt", 32'(corr_cnt), exp_corr);
        check_eq("uncorr_cnt", 32'(uncorr_cnt), exp_unc);
`endif
        hs = out_valid && rdy;
        if (out_valid) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q[0];
                check_eq("data_out", 32'(data_out), 32'(e.data));
                check_eq("single_err", 32'(single_err), 32'(e.single));
                check_eq("uncorr_err", 32'(uncorr_err), 32'(e.uncorr));
                check_eq("syndrome_out", 32'(syndrome_out), 32'(e.syn));
            end
        end
        acc = v && in_ready;
        if (hs && q.size() != 0) begin
            void'(q.pop_front());
            occ--;
            delivered++;
        end
        if (acc) begin
            q.push_back(ref_decode(cw));
            occ++;
        end
`ifdef HAMMING_DEC_ERR_CNT_EN
        if (cnt_clr) begin
            exp_corr = 0;
            exp_unc  = 0;
        end else if (hs) begin
            if (e.single && exp_corr != 32'hFFFF) exp_corr++;
            if (e.uncorr && exp_unc != 32'hFFFF) exp_unc++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // Single word through an empty pipeline, checked against hand-derived constants.
    task automatic one_word(input logic [11:0] cw, input logic [7:0] d, input logic [3:0] s,
                            input logic se, input logic ue);
        logic a;
        cycle(1'b1, cw, 1'b1, 0, a);
        check_eq($sformatf("accept_%h", cw), 32'(a), 32'd1);
        cycle(1'b0, 12'h000, 1'b1, 0, a);
        check_eq($sformatf("latency_%h", cw), 32'(out_valid), 32'd1);
        check_eq($sformatf("const_data_%h", cw), 32'(data_out), 32'(d));
        check_eq($sformatf("const_syn_%h", cw), 32'(syndrome_out), 32'(s));
        check_eq($sformatf("const_single_%h", cw), 32'(single_err), 32'(se));
        check_eq($sformatf("const_uncorr_%h", cw), 32'(uncorr_err), 32'(ue));
        cycle(1'b0, 12'h000, 1'b1, 1, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        logic        rdy;
        logic [11:0] words [6];
        int          idx;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        codeword_in = '0;
        out_ready   = 1'b0;
`ifdef HAMMING_DEC_ERR_CNT_EN
        cnt_clr  = 1'b0;
        exp_corr = 0;
        exp_unc  = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_single", 32'(single_err), 32'd0);
        check_eq("rst_uncorr", 32'(uncorr_err), 32'd0);
        check_eq("rst_syndrome", 32'(syndrome_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed words; 0xB3F (bits 4 and 8 of 0xA2F flipped) carries raw payload 0xB7.
        one_word(12'hA2F, 8'hA5, 4'b0000, 1'b0, 1'b0);
        one_word(12'h000, 8'h00, 4'b0000, 1'b0, 1'b0);
        one_word(12'hA0F, 8'hA5, 4'b0101, 1'b1, 1'b0);
        one_word(12'hA2E, 8'hA5, 4'b0001, 1'b1, 1'b0);
        one_word(12'hA27, 8'hA5, 4'b0111, 1'b1, 1'b0);
        one_word(12'hB3F, 8'hB7, 4'b1100, 1'b0, 1'b1);

`ifdef HAMMING_DEC_ERR_CNT_EN
        check_eq("cnt_corr_3", 32'(corr_cnt), 32'd3);
        check_eq("cnt_uncorr_1", 32'(uncorr_cnt), 32'd1);
        cnt_clr = 1'b1;
        one_word(12'hA0F, 8'hA5, 4'b0101, 1'b1, 1'b0);
        cnt_clr = 1'b0;
        check_eq("cnt_clr_corr", 32'(corr_cnt), 32'd0);
        check_eq("cnt_clr_uncorr", 32'(uncorr_cnt), 32'd0);
`endif

        // Full-rate stream: no bubbles once the pipeline fills.
        for (int k = 0; k < 12; k++) begin
            cycle(k < 10, 12'($urandom), 1'b1, (k >= 2) ? 1 : 0, a);
        end

        // Back-pressure: six words, random out_ready with a forced 4-cycle stall.
        for (int i = 0; i < 6; i++) words[i] = 12'($urandom);
        idx = 0;
        delivered = 0;
        for (int t = 0; t < 200 && delivered < 6; t++) begin
            rdy = (t >= 3 && t < 7) ? 1'b0 : 1'($urandom);
            cycle(idx < 6, words[(idx < 6) ? idx : 0], rdy, -1, a);
            if (a) idx++;
        end
        check_eq("bp_delivered", 32'(delivered), 32'd6);

        // Random traffic, then a bounded drain.
        for (int t = 0; t < 400; t++) begin
            cycle(1'($urandom), 12'($urandom), ($urandom_range(0, 3) != 0), -1, a);
        end
        for (int t = 0; t < 20 && occ > 0; t++) cycle(1'b0, 12'h000, 1'b1, -1, a);
        check_eq("drain_empty", 32'(occ), 32'd0);

        // Reset with two words in flight: outputs drop at once, nothing stale afterwards.
        cycle(1'b1, 12'($urandom), 1'b1, -1, a);
        cycle(1'b1, 12'($urandom), 1'b1, -1, a);
        check_eq("pre_rst_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_data_out", 32'(data_out), 32'd0);
        check_eq("midrst_single", 32'(single_err), 32'd0);
        check_eq("midrst_uncorr", 32'(uncorr_err), 32'd0);
        q.delete();
        occ = 0;
`ifdef HAMMING_DEC_ERR_CNT_EN
        exp_corr = 0;
        exp_unc  = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int t = 0; t < 5; t++) cycle(1'b0, 12'h000, 1'b1, 0, a);
        one_word(12'hA2F, 8'hA5, 4'b0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
